mux_rr_arb: RTL and testbench

- Parametrised N-channel, W-bit multiplexer with a registered output, replacing the fixed 4:1 combinational mux.
- Each channel has a valid/ready handshake. A runtime mode selects either round-robin arbitration or a fixed select, which keeps the classic mux behaviour.
- Sits between several producers and one consumer. It gives one beat of output buffering and reports which source channel each beat came from.

---
 rtl/mux_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/mux_rr_arb.sv | 90 +++++++++
 tb/tb_mux_rr_arb.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and the rotating-priority search used by the round-robin mux.
package mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    localparam int unsigned DEFAULT_N = 4;
    localparam int unsigned DEFAULT_W = 8;

    // Upper bound on channel count supported by rr_search.
    localparam int unsigned MAX_N = 64;

    // First set bit of req[n-1:0] scanning ptr, ptr+1, ... with wrap; -1 if none.
    function automatic int rr_search(input logic [MAX_N-1:0] req, input int n, input int ptr);
        int  result;
        int  idx;
        logic found;
        result = -1;
        found  = 1'b0;
        for (int k = 0; k < int'(MAX_N); k++) begin
            if (k < n && !found) begin
                idx = (ptr + k) % n;
                if (req[idx]) begin
                    result = idx;
                    found  = 1'b1;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant logic: rotating priority from ptr, or a fixed channel select.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned N  = DEFAULT_N,
    parameter int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          mode,
    input  logic [SW-1:0] sel,
    output logic          grant_valid,
    output logic [SW-1:0] grant
);

    logic [MAX_N-1:0] req_ext;
    int               rr_idx;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        rr_idx         = rr_search(req_ext, int'(N), int'(ptr));
    end

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        if (mode == MODE_RR) begin
            if (rr_idx >= 0) begin
                grant_valid = 1'b1;
                grant       = SW'(rr_idx);
            end
        end else begin
            // An out-of-range sel matches no channel and so yields no grant.
            for (int i = 0; i < int'(N); i++) begin
                if (sel == SW'(i) && req[i]) begin
                    grant_valid = 1'b1;
                    grant       = SW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel valid/ready mux with one registered output beat and source-channel tagging.
module mux_rr_arb
    import mux_pkg::*;
#(
    parameter int unsigned N  = DEFAULT_N,
    parameter int unsigned W  = DEFAULT_W,
    parameter int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    input  logic           out_ready
);

    logic          out_valid_q;
    logic [W-1:0]  out_data_q;
    logic [SW-1:0] out_ch_q;
    logic [SW-1:0] ptr_q;
    logic [SW-1:0] ptr_d;

    logic          load;
    logic          grant_valid;
    logic [SW-1:0] grant;
    logic          xfer;
    logic [W-1:0]  grant_data;

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .req         (in_valid),
        .ptr         (ptr_q),
        .mode        (mode),
        .sel         (sel),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    assign load = !out_valid_q || out_ready;

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            // Gated by rst so no handshake can complete while reset is held.
            in_ready[i] = !rst && load && grant_valid && (grant == SW'(i));
            if (grant == SW'(i)) begin
                grant_data = in_data[i*W +: W];
            end
        end
        xfer = |(in_valid & in_ready);
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer && mode == MODE_RR) begin
            ptr_d = (grant == SW'(N - 1)) ? '0 : grant + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= grant_data;
                out_ch_q    <= grant;
            end else if (load) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Scoreboard bench for mux_rr_arb: directed stimulus pushes expected beats, a monitor checks them.
module tb_mux_rr_arb;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    typedef struct packed {
        logic [SW-1:0] ch;
        logic [W-1:0]  data;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_ready;

    int    tests = 0;
    int    fails = 0;
    beat_t exp_q[$];

    mux_rr_arb #(
        .N  (N),
        .W  (W),
        .SW (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_beat(input logic [SW-1:0] ch, input logic [W-1:0] data);
        beat_t b;
        b.ch   = ch;
        b.data = data;
        exp_q.push_back(b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every beat the consumer accepts must match the next expected beat.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got ch %0d data 0x%0h, expected none", out_ch, out_data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_ch", 32'(out_ch), 32'(e.ch));
                check("beat_data", 32'(out_data), 32'(e.data));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_data   = 32'h3322_1100;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b1;

        // Reset state.
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;

        // Round-robin, all valid: strict rotation 0,1,2,3,0.
        expect_beat(2'd0, 8'h00);
        expect_beat(2'd1, 8'h11);
        expect_beat(2'd2, 8'h22);
        expect_beat(2'd3, 8'h33);
        expect_beat(2'd0, 8'h00);
        repeat (5) step();

        // Sparse, ptr = 1, channels 0 and 3: 3, 0 (wrap), 3.
        in_valid = 4'b1001;
        expect_beat(2'd3, 8'h33);
        expect_beat(2'd0, 8'h00);
        expect_beat(2'd3, 8'h33);
        repeat (3) step();
        in_valid = 4'b0000;
        step();
        @(negedge clk);
        check("empty_out_valid", 32'(out_valid), 32'd0);
        check("empty_out_data_hold", 32'(out_data), 32'h33);
        check("empty_out_ch_hold", 32'(out_ch), 32'd3);
        step();

        // Fixed select 2, then sel = 1 mid-stream, then back to round-robin from ptr = 0.
        mode     = 1'b1;
        sel      = 2'd2;
        in_valid = 4'b1111;
        expect_beat(2'd2, 8'h22);
        expect_beat(2'd2, 8'h22);
        expect_beat(2'd2, 8'h22);
        repeat (3) step();
        sel = 2'd1;
        expect_beat(2'd1, 8'h11);
        expect_beat(2'd1, 8'h11);
        repeat (2) step();
        mode = 1'b0;
        expect_beat(2'd0, 8'h00);
        expect_beat(2'd1, 8'h11);
        repeat (2) step();

        // Back-pressure with channel 1 beat held.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_ch", 32'(out_ch), 32'd1);
            check("bp_out_data", 32'(out_data), 32'h11);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("drain_fill_in_ready", 32'(in_ready), 32'b0100);
        expect_beat(2'd2, 8'h22);
        step();
        in_valid = 4'b0000;
        check("no_bubble_out_valid", 32'(out_valid), 32'd1);
        check("no_bubble_out_ch", 32'(out_ch), 32'd2);
        step();

        // Reset mid-stream with a held beat from channel 3.
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        step();
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        check("pre_rst_out_ch", 32'(out_ch), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_data", 32'(out_data), 32'd0);
        check("async_rst_out_ch", 32'(out_ch), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        expect_beat(2'd0, 8'h00);
        step();
        in_valid = 4'b0000;
        repeat (2) step();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
